// File: rtl/renkon_pkg.sv
// renkon_pkg: shared defaults and state encoding for the renkon output path
// Holds the default pixel/address/FIFO sizes and the writer FSM state type.
package renkon_pkg;
   localparam int DEF_DWIDTH     = 16;
   localparam int DEF_MEMSIZE    = 12;
   localparam int DEF_FDEPTH_LOG = 3;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/renkon_fifo.sv
// renkon_fifo: single-clock first-word-fall-through FIFO
// Ports: clk, xrst (async active-low), push/din write side, pop/dout read side,
// empty/full status. Push while full is taken only when a pop happens that cycle.
module renkon_fifo #(
   parameter int W    = 16,
   parameter int DLOG = 3
) (
   input  logic         clk,
   input  logic         xrst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);
   logic [W-1:0] mem [2**DLOG];
   logic [DLOG:0] wp, rp;
   logic do_push, do_pop;
   assign empty   = wp == rp;
   assign full    = (wp[DLOG] != rp[DLOG]) && (wp[DLOG-1:0] == rp[DLOG-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rp[DLOG-1:0]];
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + (DLOG+1)'(1);
         if (do_pop) rp <= rp + (DLOG+1)'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wp[DLOG-1:0]] <= din;
   end
endmodule

// File: rtl/renkon_pixel_writer.sv
// renkon_pixel_writer: buffers the activation pixel stream and writes it to memory
// Ports: start/base_addr/out_count arm a tile; out_en/pixel_in feed the FIFO;
// mem_ready/mem_we/mem_addr/mem_wdata form the memory write port;
// busy/done/overflow report tile status. xrst is async active-low.
module renkon_pixel_writer
   import renkon_pkg::*;
#(
   parameter int DWIDTH     = DEF_DWIDTH,
   parameter int MEMSIZE    = DEF_MEMSIZE,
   parameter int FDEPTH_LOG = DEF_FDEPTH_LOG
) (
   input  logic               clk,
   input  logic               xrst,
   input  logic               start,
   input  logic [MEMSIZE-1:0] base_addr,
   input  logic [MEMSIZE-1:0] out_count,
   input  logic               out_en,
   input  logic [DWIDTH-1:0]  pixel_in,
   input  logic               mem_ready,
   output logic               mem_we,
   output logic [MEMSIZE-1:0] mem_addr,
   output logic [DWIDTH-1:0]  mem_wdata,
   output logic               busy,
   output logic               done,
   output logic               overflow
);
   state_t state, nxt;
   logic [MEMSIZE-1:0] addr, target, accepted, written;
   logic [DWIDTH-1:0] head;
   logic empty, full, push_req, push, pop, drop;
   assign busy = state == RUN;
   assign done = state == DONE;
   // a full FIFO still takes a pixel when the head drains in the same cycle
   assign push_req = busy && out_en && (accepted < target);
   assign pop      = busy && !empty && mem_ready;
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;
   renkon_fifo #(.W(DWIDTH), .DLOG(FDEPTH_LOG)) u_fifo (
      .clk   (clk),
      .xrst  (xrst),
      .push  (push),
      .pop   (pop),
      .din   (pixel_in),
      .dout  (head),
      .empty (empty),
      .full  (full)
   );
   always_comb begin
      nxt = state;
      if (state == IDLE && start) nxt = (out_count == '0) ? DONE : RUN;
      else if (state == RUN && pop && (written + MEMSIZE'(1) == target)) nxt = DONE;
      else if (state == DONE) nxt = IDLE;
   end
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state     <= IDLE;
         addr      <= '0;
         target    <= '0;
         accepted  <= '0;
         written   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         overflow  <= 1'b0;
      end else begin
         state  <= nxt;
         mem_we <= pop;
         if (state == IDLE && start) begin
            addr     <= base_addr;
            target   <= out_count;
            accepted <= '0;
            written  <= '0;
            overflow <= 1'b0;
         end
         if (push) accepted <= accepted + MEMSIZE'(1);
         if (drop) overflow <= 1'b1;
         if (pop) begin
            mem_addr  <= addr;
            mem_wdata <= head;
            addr      <= addr + MEMSIZE'(1);
            written   <= written + MEMSIZE'(1);
         end
      end
   end
endmodule

// File: tb/tb_renkon_pixel_writer.sv
// tb_renkon_pixel_writer: scoreboard bench for the pixel writer
module tb_renkon_pixel_writer;
   localparam int DW = 16;
   localparam int MS = 12;
   logic clk = 1'b0, xrst = 1'b0, start = 1'b0, out_en = 1'b0, mem_ready = 1'b0;
   logic [MS-1:0] base_addr = '0, out_count = '0;
   logic [DW-1:0] pixel_in = '0;
   logic mem_we, busy, done, overflow;
   logic [MS-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   int tests = 0, fails = 0, done_cnt = 0, d0;
   logic [MS+DW-1:0] exp_q[$];
   logic [MS+DW-1:0] e_w;

   renkon_pixel_writer dut (
      .clk(clk), .xrst(xrst), .start(start), .base_addr(base_addr),
      .out_count(out_count), .out_en(out_en), .pixel_in(pixel_in),
      .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(string n, logic [31:0] a, logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (xrst && mem_we) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
         end else begin
            e_w = exp_q.pop_front();
            check("sb_write", {4'h0, mem_addr, mem_wdata}, {4'h0, e_w});
         end
      end
      if (xrst && done) done_cnt++;
   end

   task automatic ew(logic [MS-1:0] a, logic [DW-1:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(logic [MS-1:0] a, logic [MS-1:0] c);
      base_addr = a;
      out_count = c;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic px(logic [DW-1:0] v);
      out_en = 1'b1;
      pixel_in = v;
      tick();
      out_en = 1'b0;
   endtask

   task automatic wait_idle(string n);
      int k = 0;
      while (busy && k < 60) begin
         tick();
         k++;
      end
      check({n, "_timeout"}, busy, 0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", mem_wdata, 0);
      check("rst_flags", {busy, done, overflow}, 0);
      tick();
      xrst = 1'b1;
      tick();
      // basic transfer with latency check
      mem_ready = 1'b1;
      d0 = done_cnt;
      do_start(12'h100, 4);
      check("basic_busy", busy, 1);
      ew(12'h100, 16'd5); ew(12'h101, 16'hFFFD); ew(12'h102, 16'd0); ew(12'h103, 16'd127);
      px(16'd5);
      check("lat_n1", mem_we, 0);
      px(16'hFFFD);
      check("lat_n2", {mem_we, mem_addr, mem_wdata}, {1'b1, 12'h100, 16'd5});
      px(16'd0);
      px(16'd127);
      wait_idle("basic");
      check("basic_done", done_cnt - d0, 1);
      check("basic_sb", exp_q.size(), 0);
      // backpressure and overflow
      mem_ready = 1'b0;
      d0 = done_cnt;
      do_start(12'h200, 12);
      for (int i = 0; i < 10; i++) begin
         px(DW'(10 + i));
         if (i < 8) ew(MS'(12'h200 + i), DW'(10 + i));
         if (i == 7) check("ovf_before", overflow, 0);
         if (i == 8) check("ovf_after9", overflow, 1);
      end
      mem_ready = 1'b1;
      repeat (12) tick();
      check("bp_drained", exp_q.size(), 0);
      check("bp_busy", busy, 1);
      for (int i = 0; i < 4; i++) begin
         ew(MS'(12'h208 + i), DW'(30 + i));
         px(DW'(30 + i));
      end
      wait_idle("bp");
      check("bp_done", done_cnt - d0, 1);
      check("ovf_sticky", overflow, 1);
      // zero count, also clears overflow
      do_start(12'h300, 0);
      check("zero_ovf_clr", overflow, 0);
      check("zero_done", {done, busy}, 2'b10);
      tick();
      check("zero_done_end", {done, busy}, 2'b00);
      // ignore rules
      repeat (3) px(16'd99);
      repeat (3) tick();
      d0 = done_cnt;
      do_start(12'h400, 2);
      ew(12'h400, 16'd1); ew(12'h401, 16'd2);
      base_addr = 12'h7AA;
      out_count = 12'd9;
      start = 1'b1;
      px(16'd1);
      start = 1'b0;
      check("ign_busy", busy, 1);
      px(16'd2);
      px(16'd7); px(16'd8); px(16'd9);
      wait_idle("ign");
      repeat (4) tick();
      check("ign_done", done_cnt - d0, 1);
      check("ign_sb", exp_q.size(), 0);
      // address wrap
      d0 = done_cnt;
      do_start(12'hFFE, 4);
      ew(12'hFFE, 16'h8000); ew(12'hFFF, 16'h7FFF); ew(12'h000, 16'hFFFF); ew(12'h001, 16'h0001);
      px(16'h8000); px(16'h7FFF); px(16'hFFFF); px(16'h0001);
      wait_idle("wrap");
      check("wrap_done", done_cnt - d0, 1);
      // full FIFO with simultaneous push and pop
      mem_ready = 1'b0;
      do_start(12'h500, 10);
      for (int i = 0; i < 10; i++) ew(MS'(12'h500 + i), DW'(16'h50 + i));
      for (int i = 0; i < 8; i++) px(DW'(16'h50 + i));
      check("full_no_ovf", overflow, 0);
      mem_ready = 1'b1;
      px(16'h58);
      check("full_pushpop", overflow, 0);
      px(16'h59);
      wait_idle("full");
      check("full_ovf_end", overflow, 0);
      check("full_sb", exp_q.size(), 0);
      // async reset mid-transfer
      d0 = done_cnt;
      do_start(12'h600, 6);
      ew(12'h600, 16'h60); ew(12'h601, 16'h61);
      px(16'h60);
      out_en = 1'b1;
      pixel_in = 16'h61; tick();
      pixel_in = 16'h62; tick();
      @(negedge clk);
      #1;
      out_en = 1'b0;
      xrst = 1'b0;
      #1;
      check("arst_we", mem_we, 0);
      check("arst_addr", mem_addr, 0);
      check("arst_data", mem_wdata, 0);
      check("arst_flags", {busy, done, overflow}, 0);
      tick();
      tick();
      xrst = 1'b1;
      repeat (4) tick();
      check("arst_no_done", done_cnt - d0, 0);
      check("arst_sb", exp_q.size(), 0);
      d0 = done_cnt;
      do_start(12'h700, 3);
      for (int i = 0; i < 3; i++) begin
         ew(MS'(12'h700 + i), DW'(16'h70 + i));
         px(DW'(16'h70 + i));
      end
      wait_idle("after_rst");
      check("after_rst_done", done_cnt - d0, 1);
      check("final_sb", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
